// File: rtl/cdp_rdma_req_gen_pkg.sv
// cdp_rdma_pkg: shared field layout, FSM states and helpers for the CDP RDMA request generator.
package cdp_rdma_pkg;
    localparam int ADDR_LSB   = 0;
    localparam int CQ_LEN_LSB = 0;
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;
    function automatic int req_len_lsb(input int aw);
        return ADDR_LSB + aw;
    endfunction
    function automatic int cq_last_bit(input int lenw);
        return CQ_LEN_LSB + lenw;
    endfunction
    function automatic int atom_shift(input int atom_bytes);
        return $clog2(atom_bytes);
    endfunction
endpackage

// File: rtl/cdp_rdma_req_gen_if.sv
// cdp_rdma_req_gen_if: MCIF/CVIF read-request and context-queue write handshakes.
interface cdp_rdma_req_gen_if #(
    parameter int AW   = 64,
    parameter int LENW = 3
);
    logic                mcif_rd_req_valid;
    logic                mcif_rd_req_ready;
    logic [AW+LENW-1:0]  mcif_rd_req_pd;
    logic                cvif_rd_req_valid;
    logic                cvif_rd_req_ready;
    logic [AW+LENW-1:0]  cvif_rd_req_pd;
    logic                cq_wr_pvld;
    logic                cq_wr_prdy;
    logic [LENW:0]       cq_wr_pd;
    modport master (
        output mcif_rd_req_valid, mcif_rd_req_pd, cvif_rd_req_valid, cvif_rd_req_pd, cq_wr_pvld, cq_wr_pd,
        input  mcif_rd_req_ready, cvif_rd_req_ready, cq_wr_prdy
    );
    modport slave (
        input  mcif_rd_req_valid, mcif_rd_req_pd, cvif_rd_req_valid, cvif_rd_req_pd, cq_wr_pvld, cq_wr_pd,
        output mcif_rd_req_ready, cvif_rd_req_ready, cq_wr_prdy
    );
endinterface

// File: rtl/cdp_rdma_req_gen_addr_walker.sv
// cdp_rdma_addr_walker: x/line/surface counters and address accumulators for the cube walk;
// presents the current burst (addr, len, last) and advances one burst per step.
module cdp_rdma_addr_walker
    import cdp_rdma_pkg::*;
#(
    parameter int AW         = 64,
    parameter int LENW       = 3,
    parameter int ATOM_BYTES = 32,
    parameter int DIMW       = 13
) (
    input  logic            nvdla_core_clk,
    input  logic            nvdla_core_rstn,
    input  logic            init_i,
    input  logic            step_i,
    input  logic [AW-1:0]   base_i,
    input  logic [31:0]     line_stride_i,
    input  logic [31:0]     surface_stride_i,
    input  logic [DIMW-1:0] width_i,
    input  logic [DIMW-1:0] height_i,
    input  logic [DIMW-1:0] surfaces_i,
    output logic [AW-1:0]   addr_o,
    output logic [LENW:0]   len_o,
    output logic            last_o
);
    localparam int            SHIFT     = atom_shift(ATOM_BYTES);
    localparam logic [DIMW:0] MAX_BURST = (DIMW+1)'(1) << LENW;

    logic [31:0]     line_stride_q, surface_stride_q;
    logic [DIMW-1:0] width_q, height_q, surfaces_q, line_q, surf_q;
    logic [DIMW:0]   x_q, rem;
    logic [AW-1:0]   addr_q, line_addr_q, surf_addr_q, next_line_addr, next_surf_addr;
    logic            eol, last_line, last_surf;

    assign rem            = {1'b0, width_q} + (DIMW+1)'(1) - x_q;
    assign eol            = rem <= MAX_BURST;
    assign last_line      = line_q == height_q;
    assign last_surf      = surf_q == surfaces_q;
    assign len_o          = eol ? rem[LENW:0] : MAX_BURST[LENW:0];
    assign last_o         = eol && last_line && last_surf;
    assign addr_o         = addr_q;
    assign next_line_addr = line_addr_q + AW'(line_stride_q);
    assign next_surf_addr = surf_addr_q + AW'(surface_stride_q);

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            line_stride_q    <= '0;
            surface_stride_q <= '0;
            width_q          <= '0;
            height_q         <= '0;
            surfaces_q       <= '0;
            x_q              <= '0;
            line_q           <= '0;
            surf_q           <= '0;
            addr_q           <= '0;
            line_addr_q      <= '0;
            surf_addr_q      <= '0;
        end else if (init_i) begin
            line_stride_q    <= line_stride_i;
            surface_stride_q <= surface_stride_i;
            width_q          <= width_i;
            height_q         <= height_i;
            surfaces_q       <= surfaces_i;
            x_q              <= '0;
            line_q           <= '0;
            surf_q           <= '0;
            addr_q           <= base_i;
            line_addr_q      <= base_i;
            surf_addr_q      <= base_i;
        end else if (step_i) begin
            if (!eol) begin
                x_q    <= x_q + (DIMW+1)'(len_o);
                addr_q <= addr_q + (AW'(len_o) << SHIFT);
            end else if (!last_line) begin
                x_q         <= '0;
                line_q      <= line_q + 1'b1;
                line_addr_q <= next_line_addr;
                addr_q      <= next_line_addr;
            end else begin
                // a new surface restarts from the surface base, not from the last line
                x_q         <= '0;
                line_q      <= '0;
                surf_q      <= surf_q + 1'b1;
                line_addr_q <= next_surf_addr;
                surf_addr_q <= next_surf_addr;
                addr_q      <= next_surf_addr;
            end
        end
    end
endmodule

// File: rtl/cdp_rdma_req_gen.sv
// cdp_rdma_req_gen: walks the input cube and issues credit-limited burst reads to MCIF or CVIF,
// recording each burst in the context queue and counting read-stall cycles.
module cdp_rdma_req_gen
    import cdp_rdma_pkg::*;
#(
    parameter int AW         = 64,
    parameter int LENW       = 3,
    parameter int ATOM_BYTES = 32,
    parameter int DIMW       = 13,
    parameter int CREDITW    = 8
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rstn,
    input  logic               reg2dp_op_en,
    input  logic               reg2dp_src_ram_type,
    input  logic [AW-1:0]      reg2dp_src_base_addr,
    input  logic [31:0]        reg2dp_src_line_stride,
    input  logic [31:0]        reg2dp_src_surface_stride,
    input  logic [DIMW-1:0]    reg2dp_width,
    input  logic [DIMW-1:0]    reg2dp_height,
    input  logic [DIMW-1:0]    reg2dp_surfaces,
    input  logic [CREDITW-1:0] reg2dp_credit_max,
    cdp_rdma_req_gen_if.master rd,
    input  logic [LENW:0]      eg_atom_ret,
    input  logic               eg2ig_done,
    output logic               op_done,
    output logic               busy,
    output logic [31:0]        dp2reg_perf_read_stall
);
    localparam int LEN_LSB = req_len_lsb(AW);
    localparam int CQ_LAST = cq_last_bit(LENW);

    state_e             state_q;
    logic               op_en_q, ram_type_q, out_vld_q, done_seen_q, op_done_q;
    logic [CREDITW-1:0] credit_max_q, credit_q, credit_d;
    logic [AW+LENW-1:0] out_pd_q, pd_d;
    logic [LENW:0]      cq_pd_d, w_len, len_m1, issued;
    logic [31:0]        stall_q;
    logic [AW-1:0]      w_addr;
    logic [CREDITW:0]   credit_sum;
    logic               w_last, op_load, start, sel_ready, accept, credit_ok, load, drain_done;

    assign op_load    = reg2dp_op_en & ~op_en_q;
    assign start      = op_load && state_q == IDLE;
    assign sel_ready  = ram_type_q ? rd.mcif_rd_req_ready : rd.cvif_rd_req_ready;
    assign accept     = out_vld_q && sel_ready;
    assign credit_sum = {1'b0, credit_q} + (CREDITW+1)'(w_len);
    assign credit_ok  = credit_sum <= {1'b0, credit_max_q};
    assign load       = state_q == REQ && (!out_vld_q || sel_ready) && rd.cq_wr_prdy && credit_ok;
    assign drain_done = state_q == DRAIN && (!out_vld_q || sel_ready) && (done_seen_q || eg2ig_done);
    assign len_m1     = w_len - (LENW+1)'(1);
    assign issued     = load ? w_len : '0;
    assign credit_d   = credit_q + CREDITW'(issued) - CREDITW'(eg_atom_ret);

    always_comb begin
        pd_d = '0;
        pd_d[ADDR_LSB +: AW] = w_addr;
        pd_d[LEN_LSB +: LENW] = len_m1[LENW-1:0];
        cq_pd_d = '0;
        cq_pd_d[CQ_LEN_LSB +: LENW] = len_m1[LENW-1:0];
        cq_pd_d[CQ_LAST] = w_last;
    end

    // the CQ entry is written in the same cycle the request register loads
    assign rd.cq_wr_pvld        = load;
    assign rd.cq_wr_pd          = load ? cq_pd_d : '0;
    assign rd.mcif_rd_req_valid = out_vld_q && ram_type_q;
    assign rd.mcif_rd_req_pd    = ram_type_q ? out_pd_q : '0;
    assign rd.cvif_rd_req_valid = out_vld_q && !ram_type_q;
    assign rd.cvif_rd_req_pd    = ram_type_q ? '0 : out_pd_q;
    assign op_done                = op_done_q;
    assign busy                   = state_q != IDLE;
    assign dp2reg_perf_read_stall = stall_q;

    cdp_rdma_addr_walker #(
        .AW(AW), .LENW(LENW), .ATOM_BYTES(ATOM_BYTES), .DIMW(DIMW)
    ) u_walker (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .init_i          (start),
        .step_i          (load),
        .base_i          (reg2dp_src_base_addr),
        .line_stride_i   (reg2dp_src_line_stride),
        .surface_stride_i(reg2dp_src_surface_stride),
        .width_i         (reg2dp_width),
        .height_i        (reg2dp_height),
        .surfaces_i      (reg2dp_surfaces),
        .addr_o          (w_addr),
        .len_o           (w_len),
        .last_o          (w_last)
    );

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q      <= IDLE;
            op_en_q      <= 1'b0;
            ram_type_q   <= 1'b0;
            credit_max_q <= '0;
            credit_q     <= '0;
            out_vld_q    <= 1'b0;
            out_pd_q     <= '0;
            done_seen_q  <= 1'b0;
            op_done_q    <= 1'b0;
            stall_q      <= '0;
        end else begin
            op_en_q   <= reg2dp_op_en;
            credit_q  <= credit_d;
            op_done_q <= 1'b0;
            if (accept)
                out_vld_q <= 1'b0;
            if (load) begin
                out_vld_q <= 1'b1;
                out_pd_q  <= pd_d;
            end
            if (out_vld_q && !sel_ready && stall_q != '1)
                stall_q <= stall_q + 32'd1;
            case (state_q)
                IDLE: if (op_load) begin
                    ram_type_q   <= reg2dp_src_ram_type;
                    credit_max_q <= reg2dp_credit_max;
                    done_seen_q  <= 1'b0;
                    stall_q      <= '0;
                    state_q      <= REQ;
                end
                REQ: begin
                    if (eg2ig_done)
                        done_seen_q <= 1'b1;
                    if (load && w_last)
                        state_q <= DRAIN;
                end
                DRAIN: begin
                    if (eg2ig_done)
                        done_seen_q <= 1'b1;
                    if (drain_done) begin
                        op_done_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge nvdla_core_clk)
        if (nvdla_core_rstn)
            assert ({1'b0, credit_q} + (CREDITW+1)'(issued) >= (CREDITW+1)'(eg_atom_ret))
                else $error("credit counter underflow");
endmodule

// File: tb/tb_cdp_rdma_req_gen.sv
// tb_cdp_rdma_req_gen: directed and randomized layers checked cycle by cycle against a
// request list computed from the cube geometry plus a credit/stall/done model.
module tb_cdp_rdma_req_gen;
    localparam int AW = 64, LENW = 3, DIMW = 13, CREDITW = 8;

    typedef struct {
        logic [63:0] a;
        int          len;
        bit          last;
    } req_t;

    logic               clk = 1'b0, rst_n = 1'b0;
    logic               op_en = 1'b0, ram_type = 1'b0, eg_done = 1'b0;
    logic [AW-1:0]      base = '0;
    logic [31:0]        ls = '0, ss = '0;
    logic [DIMW-1:0]    wd = '0, ht = '0, sf = '0;
    logic [CREDITW-1:0] cmax_r = '0;
    logic [LENW:0]      ret = '0;
    logic               op_done, busy;
    logic [31:0]        stall;
    int                 checks = 0, failures = 0, outstanding = 0;
    req_t               exp_q[$];

    always #5 clk = ~clk;

    cdp_rdma_req_gen_if #(.AW(AW), .LENW(LENW)) rd();

    cdp_rdma_req_gen #(.AW(AW), .LENW(LENW), .ATOM_BYTES(32), .DIMW(DIMW), .CREDITW(CREDITW)) dut (
        .nvdla_core_clk(clk), .nvdla_core_rstn(rst_n), .reg2dp_op_en(op_en),
        .reg2dp_src_ram_type(ram_type), .reg2dp_src_base_addr(base),
        .reg2dp_src_line_stride(ls), .reg2dp_src_surface_stride(ss),
        .reg2dp_width(wd), .reg2dp_height(ht), .reg2dp_surfaces(sf), .reg2dp_credit_max(cmax_r),
        .rd(rd), .eg_atom_ret(ret), .eg2ig_done(eg_done),
        .op_done(op_done), .busy(busy), .dp2reg_perf_read_stall(stall)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_a"}, {rd.mcif_rd_req_valid, rd.mcif_rd_req_pd, rd.cvif_rd_req_valid, rd.cvif_rd_req_pd}, '0);
        chk({tag, "_b"}, {rd.cq_wr_pvld, rd.cq_wr_pd, op_done, busy, stall}, '0);
    endtask

    task automatic run_layer(input bit ram, input logic [63:0] b, input logic [31:0] lstr, sstr,
                             input int w, h, s, cmax, rdy_pct, prdy_hold, ret_hold, stall_n,
                             input bit early_done, mid_load);
        int  n, ld, ac, stall_m, mx, len;
        bit  done_sent, done_seen, rdy, prdy, vld, exp_pvld, edone;
        logic [66:0] sel_pd;
        req_t r;
        exp_q.delete();
        for (int si = 0; si <= s; si++)
            for (int li = 0; li <= h; li++)
                for (int x = 0; x <= w; x += len) begin
                    len    = (w + 1 - x > 8) ? 8 : w + 1 - x;
                    r.a    = b + 64'(si) * 64'(sstr) + 64'(li) * 64'(lstr) + 64'(x) * 64'd32;
                    r.len  = len;
                    r.last = si == s && li == h && x + len > w;
                    exp_q.push_back(r);
                end
        n = exp_q.size();
        @(negedge clk);
        ram_type = ram; base = b; ls = lstr; ss = sstr;
        wd = DIMW'(w); ht = DIMW'(h); sf = DIMW'(s); cmax_r = CREDITW'(cmax);
        op_en = 1'b1; ret = '0; eg_done = 1'b0;
        rd.cq_wr_prdy = 1'b1; rd.mcif_rd_req_ready = 1'b1; rd.cvif_rd_req_ready = 1'b1;
        ld = 0; ac = 0; stall_m = 0; done_sent = 0; done_seen = 0;
        for (int cyc = 1; cyc <= 3000 && !done_seen; cyc++) begin
            @(negedge clk);
            op_en = mid_load && cyc == 3;
            prdy  = cyc > prdy_hold && $urandom_range(99) < 90;
            rdy   = stall_m < stall_n ? 1'b0 : $urandom_range(99) < rdy_pct;
            mx    = outstanding < 15 ? outstanding : 15;
            ret   = (cyc <= ret_hold) ? '0 : (ret_hold > 0 && cyc == ret_hold + 1) ? 4'(mx) : 4'($urandom_range(mx));
            edone = !done_sent && (early_done ? ld == n : ac == n && outstanding == 0);
            eg_done = edone;
            rd.cq_wr_prdy = prdy;
            rd.mcif_rd_req_ready = ram ? rdy : 1'($urandom);
            rd.cvif_rd_req_ready = ram ? 1'($urandom) : rdy;
            #1;
            vld = ld > ac;
            chk("op_done", op_done, ac == n && done_sent);
            chk("busy", busy, !(ac == n && done_sent));
            chk("sel_valid", ram ? rd.mcif_rd_req_valid : rd.cvif_rd_req_valid, vld);
            chk("other_port", ram ? {rd.cvif_rd_req_valid, rd.cvif_rd_req_pd} : {rd.mcif_rd_req_valid, rd.mcif_rd_req_pd}, '0);
            sel_pd = ram ? rd.mcif_rd_req_pd : rd.cvif_rd_req_pd;
            if (vld)
                chk("req_pd", sel_pd, {3'(exp_q[ac].len - 1), exp_q[ac].a});
            exp_pvld = ld < n && (!vld || rdy) && prdy && outstanding + exp_q[ld < n ? ld : 0].len <= cmax;
            chk("cq_pvld", rd.cq_wr_pvld, exp_pvld);
            if (rd.cq_wr_pvld && ld < n)
                chk("cq_pd", rd.cq_wr_pd, {exp_q[ld].last, 3'(exp_q[ld].len - 1)});
            if (vld && rdy) ac++;
            if (vld && !rdy) stall_m++;
            if (rd.cq_wr_pvld && ld < n) begin
                outstanding += exp_q[ld].len;
                ld++;
            end
            outstanding -= int'(ret);
            if (edone) done_sent = 1;
            if (op_done) done_seen = 1;
        end
        chk("op_done_seen", done_seen, 1'b1);
        @(negedge clk);
        op_en = 1'b0; eg_done = 1'b0; ret = '0;
        #1;
        chk("idle_busy", {busy, op_done}, 2'b00);
        chk("stall_cnt", stall, stall_m);
        repeat (3) @(negedge clk);
        #1;
        chk("stall_hold", stall, stall_m);
    endtask

    initial begin
        rd.cq_wr_prdy = 1'b0; rd.mcif_rd_req_ready = 1'b0; rd.cvif_rd_req_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_quiet("reset");
        rst_n = 1'b1;
        // MCIF single line of 20 atoms
        run_layer(1, 64'h1000, 0, 0, 19, 0, 0, 64, 100, 0, 0, 0, 0, 0);
        // CVIF two surfaces of three 4-atom lines
        run_layer(0, 64'h0, 32'h200, 32'h1000, 3, 2, 1, 64, 100, 0, 0, 0, 0, 0);
        // credit of 8 with returns held off, then all 8 returned at once
        run_layer(1, 64'h2000, 0, 0, 31, 0, 0, 8, 100, 0, 10, 0, 0, 0);
        // first request stalled for 10 cycles
        run_layer(1, 64'h3000, 32'h400, 0, 10, 1, 0, 255, 100, 0, 0, 10, 0, 0);
        // CQ back-pressure for 5 cycles plus an ignored mid-layer start edge
        run_layer(0, 64'h4000, 32'h100, 32'h800, 9, 1, 1, 32, 70, 5, 0, 0, 0, 1);
        // degenerate cube, egress done arrives before acceptance
        run_layer(1, 64'h5000, 0, 0, 0, 0, 0, 16, 100, 0, 0, 3, 1, 0);
        for (int i = 0; i < 8; i++) begin
            logic [63:0] rb;
            rb = {$urandom, $urandom} & ~64'h1F;
            if (i % 2 == 1) rb[63:20] = '1;
            run_layer(1'($urandom), rb, 32'($urandom_range(64, 1)) << 5, 32'($urandom_range(512, 1)) << 5,
                      $urandom_range(40), $urandom_range(3), $urandom_range(2), $urandom_range(255, 8),
                      $urandom_range(100, 50), $urandom_range(3), 0, 0, 1'($urandom), 0);
        end
        // reset while requests are pending
        @(negedge clk);
        ram_type = 1'b1; base = 64'h6000; ls = 32'h1000; wd = 13'd100; ht = 13'd3; sf = '0; cmax_r = 8'd255;
        op_en = 1'b1; rd.cq_wr_prdy = 1'b1; rd.mcif_rd_req_ready = 1'b0; ret = '0;
        repeat (4) @(negedge clk) op_en = 1'b0;
        #1;
        chk("pre_rst", {busy, rd.mcif_rd_req_valid, stall != 0}, 3'b111);
        #2 rst_n = 1'b0;
        #1;
        chk_quiet("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        outstanding = 0;
        #1;
        chk("post_rst_busy", busy, 1'b0);
        run_layer(0, 64'h7000, 0, 0, 12, 0, 0, 16, 80, 0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
